// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared definitions for the cpu_io memory-mapped responder.
//   - register offsets within the 8-byte window (AD[2:0])
//   - CTRL and STAT bit indices
//   - wait-state phase encoding used by the bus-side FSM
package cpu_io_pkg;

  localparam logic [2:0] REG_TIM_LO  = 3'd0;
  localparam logic [2:0] REG_TIM_HI  = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_STAT    = 3'd3;
  localparam logic [2:0] REG_SCRATCH = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam int STAT_TF = 0;

  // Phase of the current bus cycle as seen by the responder.
  typedef enum logic [1:0] {
    WS_IDLE   = 2'd0,  // address outside the window
    WS_STALL  = 2'd1,  // in window, RDY held low
    WS_COMMIT = 2'd2   // in window, RDY high: access completes on this edge
  } wait_phase_t;

endpackage

// File: rtl/cpu_io_timer.sv
// cpu_io_timer: prescaled 16-bit down-counter with reload and timeout flag.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : CTRL.EN, runs prescaler and counter
//   auto_rl    : CTRL.AUTO, reload on underflow instead of stopping
//   ld_lo      : strobe, reload[7:0] <= wd
//   ld_hi      : strobe, reload[15:8] <= wd and counter <= full reload
//   tf_clr     : strobe, clear TF (an underflow on the same edge wins)
//   wd         : write data for the load strobes
//   count      : live counter value
//   tf         : timeout flag
//   en_clr     : one-shot underflow this edge; parent should clear EN
module cpu_io_timer #(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        auto_rl,
  input  logic        ld_lo,
  input  logic        ld_hi,
  input  logic        tf_clr,
  input  logic [7:0]  wd,
  output logic [15:0] count,
  output logic        tf,
  output logic        en_clr
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;
  logic [15:0]   reload;
  logic          tick;
  logic          uflow;

  // A TIM_HI load on the same edge swallows the tick.
  assign tick   = en && (psc == PS_LAST) && !ld_hi;
  assign uflow  = tick && (count == 16'h0000);
  assign en_clr = uflow && !auto_rl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc    <= '0;
      reload <= 16'hFFFF;
      count  <= 16'hFFFF;
      tf     <= 1'b0;
    end else begin
      if (ld_hi) begin
        psc <= '0;
      end else if (en) begin
        psc <= (psc == PS_LAST) ? '0 : psc + 1'b1;
      end

      if (ld_lo) begin
        reload[7:0] <= wd;
      end

      if (ld_hi) begin
        reload[15:8] <= wd;
        count        <= {wd, reload[7:0]};
      end else if (tick) begin
        if (count != 16'h0000) begin
          count <= count - 16'd1;
        end else if (auto_rl) begin
          count <= reload;
        end
      end

      // Set beats clear when both land on the same edge.
      if (uflow) begin
        tf <= 1'b1;
      end else if (tf_clr) begin
        tf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_io.sv
// cpu_io: memory-mapped I/O responder on the 65C02 bus.
//   Decodes the window {BASE, 5'b0, AD[2:0]}, returns registered read data
//   one cycle after the commit edge (same as synchronous RAM), inserts
//   WAIT_STATES RDY-low cycles per access, and hosts a prescaled timer
//   driving IRQ.
// Parameters: BASE (address page), WAIT_STATES (0..7), PRESCALE (>=1)
// Ports:
//   clk  : CPU clock            RST : async active-high reset
//   AD   : CPU address          WD  : CPU write data    WE : write enable
//   RD   : registered read data HIT : RD valid this cycle
//   RDY  : combinational stall  IRQ : level interrupt, TF & IE
// Build option: CPU_IO_LATCH_EN adds a TIM_HI snapshot captured by a TIM_LO
//   read, giving atomic 16-bit counter reads in LO-then-HI order.
module cpu_io
  import cpu_io_pkg::*;
#(
  parameter logic [7:0] BASE        = 8'hFE,
  parameter int         WAIT_STATES = 0,
  parameter int         PRESCALE    = 16
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  WD,
  input  logic        WE,
  output logic [7:0]  RD,
  output logic        HIT,
  output logic        RDY,
  output logic        IRQ
);

  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES);

  // Handshake: the CPU holds AD/WE/WD while RDY=0; an access completes
  // (commits) on exactly one rising edge, the first one where the address
  // is in the window and RDY=1. Leaving the window before that edge
  // abandons the access with no side effects.
  wait_phase_t phase;
  logic        sel;
  logic [2:0]  wcnt;
  logic [2:0]  wcnt_nxt;
  logic        commit;
  logic        wr;
  logic        rd_en;
  logic [2:0]  addr;

  logic [2:0]  ctrl;
  logic [7:0]  scratch;
  logic [7:0]  rdata;

  logic [15:0] count;
  logic        tf;
  logic        en_clr;
  logic        ld_lo;
  logic        ld_hi;
  logic        tf_clr;
  logic        ctrl_wr;

  assign sel  = (AD[15:8] == BASE) && (AD[7:3] == 5'd0);
  assign addr = AD[2:0];

  always_comb begin
    phase    = WS_IDLE;
    RDY      = 1'b1;
    wcnt_nxt = 3'd0;
    if (sel) begin
      if (wcnt != WS_LAST) begin
        phase    = WS_STALL;
        RDY      = 1'b0;
        wcnt_nxt = wcnt + 3'd1;
      end else begin
        phase = WS_COMMIT;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wcnt <= 3'd0;
    end else begin
      wcnt <= wcnt_nxt;
    end
  end

  assign commit  = (phase == WS_COMMIT);
  assign wr      = commit && WE;
  assign rd_en   = commit && !WE;
  assign ld_lo   = wr && (addr == REG_TIM_LO);
  assign ld_hi   = wr && (addr == REG_TIM_HI);
  assign ctrl_wr = wr && (addr == REG_CTRL);
  assign tf_clr  = wr && (addr == REG_STAT) && WD[STAT_TF];

  cpu_io_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk     (clk),
    .rst     (RST),
    .en      (ctrl[CTRL_EN]),
    .auto_rl (ctrl[CTRL_AUTO]),
    .ld_lo   (ld_lo),
    .ld_hi   (ld_hi),
    .tf_clr  (tf_clr),
    .wd      (WD),
    .count   (count),
    .tf      (tf),
    .en_clr  (en_clr)
  );

  // A CTRL write on the underflow edge overrides the one-shot EN clear.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ctrl    <= 3'b000;
      scratch <= 8'h00;
    end else begin
      if (ctrl_wr) begin
        ctrl <= WD[2:0];
      end else if (en_clr) begin
        ctrl[CTRL_EN] <= 1'b0;
      end
      if (wr && (addr == REG_SCRATCH)) begin
        scratch <= WD;
      end
    end
  end

`ifdef CPU_IO_LATCH_EN
  logic [7:0] snap;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      snap <= 8'hFF;
    end else if (rd_en && (addr == REG_TIM_LO)) begin
      snap <= count[15:8];
    end
  end
`endif

  always_comb begin
    rdata = 8'h00;
    case (addr)
      REG_TIM_LO:  rdata = count[7:0];
`ifdef CPU_IO_LATCH_EN
      REG_TIM_HI:  rdata = snap;
`else
      REG_TIM_HI:  rdata = count[15:8];
`endif
      REG_CTRL:    rdata = {5'b00000, ctrl};
      REG_STAT:    rdata = {7'b0000000, tf};
      REG_SCRATCH: rdata = scratch;
      default:     rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      RD  <= 8'h00;
      HIT <= 1'b0;
    end else begin
      HIT <= rd_en;
      if (rd_en) begin
        RD <= rdata;
      end
    end
  end

  assign IRQ = tf & ctrl[CTRL_IE];

endmodule

// File: tb/tb_cpu_io.sv
// tb_cpu_io: directed bench for cpu_io with WAIT_STATES=2, PRESCALE=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge.
module tb_cpu_io;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] AD;
  logic [7:0]  WD;
  logic        WE;
  logic [7:0]  RD;
  logic        HIT;
  logic        RDY;
  logic        IRQ;

  int n_assert = 0;
  int n_fail   = 0;

  cpu_io #(.BASE(8'hFE), .WAIT_STATES(2), .PRESCALE(4)) dut (
    .clk (clk),
    .RST (RST),
    .AD  (AD),
    .WD  (WD),
    .WE  (WE),
    .RD  (RD),
    .HIT (HIT),
    .RDY (RDY),
    .IRQ (IRQ)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One bus access: present address after a rising edge, count RDY-low
  // cycles, let the commit edge pass, then leave the window.
  task automatic bus(input logic [15:0] a, input logic we, input logic [7:0] d,
                     output int stalls);
    logic done;
    done   = 1'b0;
    stalls = 0;
    @(posedge clk);
    #1;
    AD = a; WE = we; WD = d;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (RDY === 1'b1) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    chk("bus_rdy_timeout", 16'(done), 16'd1);
    @(posedge clk);
    #1;
    AD = 16'h0000; WE = 1'b0; WD = 8'h00;
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    int st;
    bus(a, 1'b1, d, st);
  endtask

  task automatic rd_reg(input logic [15:0] a, output logic [7:0] data,
                        output logic hit, output int stalls);
    bus(a, 1'b0, 8'h00, stalls);
    @(negedge clk);
    data = RD;
    hit  = HIT;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] data;
    logic       hit;
    int         st;

    RST = 1'b1; AD = 16'h0000; WD = 8'h00; WE = 1'b0;
    @(negedge clk);
    chk("rst_rd",  16'(RD),  16'h0000);
    chk("rst_hit", 16'(HIT), 16'h0000);
    chk("rst_rdy", 16'(RDY), 16'h0001);
    chk("rst_irq", 16'(IRQ), 16'h0000);
    @(posedge clk);
    #1 RST = 1'b0;

    // reset values of the counter
    rd_reg(16'hFE00, data, hit, st);
    chk("rst_tim_lo", 16'(data), 16'h00FF);
    chk("rst_tim_lo_hit", 16'(hit), 16'h0001);
    rd_reg(16'hFE01, data, hit, st);
    chk("rst_tim_hi", 16'(data), 16'h00FF);
    rd_reg(16'hFE02, data, hit, st);
    chk("rst_ctrl", 16'(data), 16'h0000);
    rd_reg(16'hFE03, data, hit, st);
    chk("rst_stat", 16'(data), 16'h0000);

    // wait states and scratch
    bus(16'hFE04, 1'b1, 8'h5A, st);
    chk("wr_stalls", 16'(st), 16'd2);
    @(negedge clk);
    chk("wr_hit", 16'(HIT), 16'h0000);
    rd_reg(16'hFE04, data, hit, st);
    chk("rd_stalls", 16'(st), 16'd2);
    chk("scratch", 16'(data), 16'h005A);
    chk("scratch_hit", 16'(hit), 16'h0001);

    // out-of-window address: no stall, no hit, RD holds
    @(posedge clk);
    #1 AD = 16'hFE0C;
    @(negedge clk);
    chk("oow_rdy", 16'(RDY), 16'h0001);
    @(negedge clk);
    chk("oow_hit", 16'(HIT), 16'h0000);
    chk("oow_rd_hold", 16'(RD), 16'h005A);
    AD = 16'h0000;

    // unused registers
    wr_reg(16'hFE05, 8'hAA);
    rd_reg(16'hFE05, data, hit, st);
    chk("unused_reg", 16'(data), 16'h0000);

    // one-shot timer: reload 2, PRESCALE 4 -> TF 12 clk after CTRL commit
    wr_reg(16'hFE00, 8'h02);
    wr_reg(16'hFE01, 8'h00);
    wr_reg(16'hFE02, 8'h05);
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("oneshot_irq_early", 16'(IRQ), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("oneshot_irq", 16'(IRQ), 16'h0001);
    rd_reg(16'hFE02, data, hit, st);
    chk("oneshot_en_clr", 16'(data), 16'h0004);
    rd_reg(16'hFE03, data, hit, st);
    chk("oneshot_tf", 16'(data), 16'h0001);

    // clear TF, then auto-reload with reload 1: underflow every 8 clk
    wr_reg(16'hFE03, 8'h01);
    @(negedge clk);
    chk("tf_clear_irq", 16'(IRQ), 16'h0000);
    wr_reg(16'hFE00, 8'h01);
    wr_reg(16'hFE01, 8'h00);
    wr_reg(16'hFE02, 8'h07);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("auto_irq1", 16'(IRQ), 16'h0001);
    wr_reg(16'hFE03, 8'h01);          // commits 12 clk after CTRL: no underflow
    @(negedge clk);
    chk("auto_clr_irq", 16'(IRQ), 16'h0000);
    wr_reg(16'hFE03, 8'h01);          // commits 16 clk after CTRL: underflow
    @(negedge clk);
    chk("auto_set_wins", 16'(IRQ), 16'h0001);
    rd_reg(16'hFE03, data, hit, st);
    chk("auto_stat", 16'(data), 16'h0001);
    rd_reg(16'hFE02, data, hit, st);
    chk("auto_ctrl", 16'(data), 16'h0007);

    // high-byte read across a tick: counter 0x0100, EN only
    wr_reg(16'hFE02, 8'h00);
    wr_reg(16'hFE00, 8'h00);
    wr_reg(16'hFE01, 8'h01);
    wr_reg(16'hFE02, 8'h01);
    rd_reg(16'hFE00, data, hit, st);   // commits before the first tick
    chk("snap_lo", 16'(data), 16'h0000);
    rd_reg(16'hFE01, data, hit, st);   // first tick made the counter 0x00FF
`ifdef CPU_IO_LATCH_EN
    chk("snap_hi", 16'(data), 16'h0001);
`else
    chk("live_hi", 16'(data), 16'h0000);
`endif
    rd_reg(16'hFE00, data, hit, st);   // second tick: 0x00FE
    chk("live_lo", 16'(data), 16'h00FE);

    // reset during the second wait cycle of a scratch write
    @(posedge clk);
    #1 AD = 16'hFE04; WE = 1'b1; WD = 8'h77;
    @(negedge clk);
    chk("midwait_rdy0", 16'(RDY), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    #1;
    chk("midwait_hit", 16'(HIT), 16'h0000);
    @(posedge clk);
    #1 RST = 1'b0; AD = 16'h0000; WE = 1'b0; WD = 8'h00;
    #1;
    chk("midwait_rdy1", 16'(RDY), 16'h0001);
    chk("midwait_irq", 16'(IRQ), 16'h0000);
    rd_reg(16'hFE04, data, hit, st);
    chk("midwait_scratch", 16'(data), 16'h0000);
    rd_reg(16'hFE02, data, hit, st);
    chk("midwait_ctrl", 16'(data), 16'h0000);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_io.md
# cpu_io

Memory-mapped I/O responder for the 65C02 core: the target side of the CPU bus (AD, DO, WE, DI, RDY, IRQ). It decodes one 8-register window, returns read data with the same one-cycle latency as the synchronous RAM, and inserts programmable wait states via RDY. It contains a 16-bit prescaled down-counter timer that drives the CPU IRQ input. It sits beside RAM/ROM on the top-level bus; the top level selects its read data into the CPU DI when HIT is high.

## Interface
- BASE, 8'hFE: address page; window is {BASE, 5'b0, AD[2:0]}
- WAIT_STATES, 0: RDY-low cycles inserted per access, 0..7
- PRESCALE, 16: clk cycles per timer tick, at least 1
- clk  in  1  CPU clock
- RST  in  1  reset; one clock, asynchronous and active-high
- AD  in  16  CPU address bus (combinatorial from CPU)
- WD  in  8  CPU write data (CPU DO)
- WE  in  1  CPU write enable
- RD  out  8  registered read data
- HIT  out  1  registered; RD is valid this cycle and must be muxed onto CPU DI
- RDY  out  1  combinatorial; 0 stalls the CPU with AD/WE/WD held
- IRQ  out  1  level interrupt request, active-high

## Operation
- sel = (AD[15:8]==BASE) && (AD[7:3]==0).
- Register map, by AD[2:0]:
  - 0 TIM_LO: read gives the counter low byte; write loads reload[7:0].
  - 1 TIM_HI: read gives the counter high byte (see Configuration); write loads reload[15:8] and copies the full reload into the counter; prescaler cleared.
  - 2 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE; bits 7:3 read 0.
  - 3 STAT: bit0 TF; write 1 clears TF, write 0 has no effect; other bits read 0.
  - 4 SCRATCH: 8-bit read/write.
  - 5–7: read 8'h00; writes ignored.
- Wait-state FSM, counter wcnt 0..WAIT_STATES:
  - RDY = ~(sel && wcnt != WAIT_STATES).
  - While sel and RDY=0, wcnt increments.
  - An access commits on the edge where sel && RDY; wcnt clears on that edge and whenever sel=0.
  - With WAIT_STATES=0, RDY is constant 1.
- Commit, read: RD <= register value; HIT <= 1 for one cycle.
- Commit, write: register updated; HIT <= 0.
- Non-committing cycles: HIT <= 0. RD holds its last value.
- Timer:
  - While EN=1, the prescaler counts 0..PRESCALE-1 and issues a tick at wrap.
  - On a tick with counter != 0: counter decrements.
  - On a tick with counter == 0: TF <= 1. If AUTO, counter <= reload; otherwise counter holds 0 and EN <= 0.
  - EN=0 freezes both the prescaler and the counter.
- IRQ = TF & IE.

## Timing
- Reset values: RD=0, HIT=0, IRQ=0, TF=0, CTRL=0, SCRATCH=0, reload=16'hFFFF, counter=16'hFFFF, prescaler=0, wcnt=0.
- RDY after reset = 1 unless sel.
- Read latency: data is on RD/HIT in the cycle after the commit edge. This matches the synchronous RAM.
- Write latency: the new value is visible to a read committed one cycle later.
- Simultaneous events:
  - Underflow and STAT-clear write on the same edge: TF is set (set wins).
  - TIM_HI write and tick on the same edge: the write wins; the tick is discarded.
  - CTRL write and an underflow on the same edge that clears EN: the CTRL write wins.
- A read of STAT returns the pre-edge value.
- RST asserted mid-wait: wcnt=0 immediately. No register is updated and HIT=0.
- AD leaving the window mid-wait (not legal while RDY=0, but): wcnt clears and no commit occurs.
- IRQ changes one cycle after the TF/IE edge (registered source, combinational AND).

## Configuration
- CPU_IO_LATCH_EN, defined:
  - A committed TIM_LO read captures counter[15:8] into an 8-bit snapshot, giving an atomic 16-bit read in LO-then-HI order.
  - A TIM_HI read returns the snapshot.
  - The snapshot resets to 8'hFF.
- Not defined: TIM_HI returns the live counter[15:8], and no snapshot register exists.

## Structure
- Shared package cpu_io_pkg holds:
  - register offsets REG_TIM_LO..REG_SCRATCH
  - CTRL bit indices CTRL_EN, CTRL_AUTO, CTRL_IE
  - STAT bit index STAT_TF
- One sub-module, cpu_io_timer, holds the prescaler, 16-bit counter, reload and TF logic. Its inputs are load strobes, EN/AUTO and tf_clr; its outputs are the counter, TF and en_clr.
- Top level cpu_io holds decode, the wait-state FSM, the register file, the read mux and the snapshot.

## Test plan
- Reset with AD=16'h0000: RD=0, HIT=0, RDY=1, IRQ=0; a read of FE00/FE01 returns 8'hFF/8'hFF.
- WAIT_STATES=2, write 8'h5A to FE04 then read FE04: RDY is low for exactly 2 cycles per access, and RD=8'h5A with HIT=1 one cycle after the read commit.
- PRESCALE=4: write reload 16'h0002 (FE00=02, FE01=00), CTRL=8'h05. TF sets 12 clk after the CTRL commit, IRQ=1 the next cycle, and EN reads 0.
- CTRL=8'h07 with reload 1: TF sets on each underflow. Writing FE03=01 on the same edge as an underflow leaves TF=1; writing it on a non-underflow edge clears TF and IRQ.
- With CPU_IO_LATCH_EN and counter 16'h0100 decrementing: read FE00 (8'h00), then after a tick read FE01; the result is 8'h01 (snapshot), while the live high byte is 8'h00.
- Assert RST during the second wait cycle of a write to FE04: SCRATCH stays 0, RDY returns to 1 once AD is outside the window, and HIT=0.
